// File: rtl/conv_bcd_bin_serie.sv
// -----------------------------------------------------------------------------
// conv_bcd_bin_serie
//   Serial packed-BCD to binary converter. It processes one digit per clock,
//   most significant digit first, using acc <= acc*10 + digit. A request of
//   N_DIG digits completes N_DIG cycles after the edge that samples inicio.
//
// Optional feature (macro CONV_BCD_ERR_EN):
//   defined   : a nibble > 9 sets a sticky flag. A flagged result is
//               reported as dato_bin = all ones with error = 1.
//   undefined : nibbles > 9 are weighted like ordinary digits, and error
//               is tied to 0.
//
// Ports
//   clk         : single clock, rising edge.
//   reset       : asynchronous, active-high reset.
//   inicio      : conversion request, sampled only in REPOSO.
//   dato_bcd    : packed BCD operand (MSD in the top nibble), sampled with inicio.
//   dato_bin    : registered binary result, held until the next completion.
//   listo       : one-cycle pulse; dato_bin/error were just updated.
//   ocupado     : high while in CONVIERTE.
//   error       : invalid-digit flag for the held result.
//   estado_dbg  : current FSM state (0 = REPOSO, 1 = CONVIERTE) for observation.
//
// Handshake: a request is accepted on any rising edge where inicio = 1 and the
// block is in REPOSO. That includes the listo cycle, so conversions can run
// back-to-back. inicio is ignored while ocupado = 1. listo marks the single
// cycle in which a new result is valid; there is no back-pressure.
// -----------------------------------------------------------------------------
module conv_bcd_bin_serie #(
   parameter int N_DIG     = 2,
   parameter int ANCHO_BIN = 7
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inicio,
   input  logic [4*N_DIG-1:0]     dato_bcd,
   output logic [ANCHO_BIN-1:0]   dato_bin,
   output logic                   listo,
   output logic                   ocupado,
   output logic                   error,
   output logic                   estado_dbg
);

   localparam int AW = ANCHO_BIN + 4;
   localparam int CW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   typedef enum logic {
      REPOSO    = 1'b0,
      CONVIERTE = 1'b1
   } estado_t;

   estado_t              r_estado;
   estado_t              w_estado_sig;
   logic                 w_captura;
   logic                 w_paso;
   logic                 w_fin;

   logic [4*N_DIG-1:0]   r_operando;
   logic [AW-1:0]        r_acc;
   logic [CW-1:0]        r_cnt;
   logic [ANCHO_BIN-1:0] r_dato_bin;
   logic                 r_listo;
   logic [3:0]           w_nib;
   logic [AW-1:0]        w_acc_sig;

   // ---------------------------------------------------------------- FSM ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_estado <= REPOSO;
      else       r_estado <= w_estado_sig;
   end

   always_comb begin
      w_estado_sig = r_estado;
      w_captura    = 1'b0;
      w_paso       = 1'b0;
      w_fin        = 1'b0;
      case (r_estado)
         REPOSO: begin
            if (inicio) begin
               w_captura    = 1'b1;
               w_estado_sig = CONVIERTE;
            end
         end
         CONVIERTE: begin
            w_paso = 1'b1;
            // Counter at 0 means this edge consumes the last nibble.
            if (r_cnt == '0) begin
               w_fin        = 1'b1;
               w_estado_sig = REPOSO;
            end
         end
         default: w_estado_sig = REPOSO;
      endcase
   end

   // ----------------------------------------------------------- datapath ----
   // Selects the nibble addressed by the digit counter in the captured operand.
   always_comb begin
      w_nib = 4'd0;
      for (int k = 0; k < N_DIG; k++) begin
         if (r_cnt == CW'(k)) w_nib = r_operando[4*k +: 4];
      end
   end

   assign w_acc_sig = r_acc * AW'(10) + AW'(w_nib);

`ifdef CONV_BCD_ERR_EN
   logic r_flag;
   logic r_error;
   logic w_flag_sig;

   // The flag is sticky across the digits of one request.
   assign w_flag_sig = r_flag | (w_nib > 4'd9);
   assign error      = r_error;
`else
   assign error      = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_operando <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_dato_bin <= '0;
         r_listo    <= 1'b0;
`ifdef CONV_BCD_ERR_EN
         r_flag     <= 1'b0;
         r_error    <= 1'b0;
`endif
      end else begin
         r_listo <= w_fin;
         if (w_captura) begin
            r_operando <= dato_bcd;
            r_acc      <= '0;
            r_cnt      <= CW'(N_DIG - 1);
`ifdef CONV_BCD_ERR_EN
            r_flag     <= 1'b0;
`endif
         end else if (w_paso) begin
            r_acc <= w_acc_sig;
            r_cnt <= w_fin ? '0 : r_cnt - CW'(1);
`ifdef CONV_BCD_ERR_EN
            r_flag <= w_flag_sig;
            if (w_fin) begin
               r_dato_bin <= w_flag_sig ? '1 : w_acc_sig[ANCHO_BIN-1:0];
               r_error    <= w_flag_sig;
            end
`else
            if (w_fin) r_dato_bin <= w_acc_sig[ANCHO_BIN-1:0];
`endif
         end
      end
   end

   assign dato_bin   = r_dato_bin;
   assign listo      = r_listo;
   assign ocupado    = (r_estado == CONVIERTE);
   assign estado_dbg = r_estado;

endmodule
